// File: rtl/hdmi_period_sched.sv
// Video timing generator and TMDS period scheduler for the HDMI output path.
// Each line and each frame start with blanking (front porch, sync, back porch)
// followed by active video. On active lines in HDMI mode the control period is
// followed by an 8-cycle video preamble and a 2-cycle guard band right before
// active video. In DVI mode only blank/sync timing is produced.
// Every output is registered and describes the counter position of the
// previous cycle.
module hdmi_period_sched #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter bit          HDMI_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  ctl,
  output logic        guard,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

  // Counter-domain constants at the 11-bit counter width.
  localparam logic [10:0] H_BLANK_W   = 11'(H_BLANK);
  localparam logic [10:0] H_LAST_W    = 11'(H_TOTAL - 1);
  localparam logic [10:0] PRE_START_W = 11'(H_BLANK - 10);
  localparam logic [10:0] GRD_START_W = 11'(H_BLANK - 2);
  localparam logic [10:0] HS_START_W  = 11'(H_FP);
  localparam logic [10:0] HS_END_W    = 11'(H_FP + H_SYNC);
  localparam logic [10:0] V_BLANK_W   = 11'(V_BLANK);
  localparam logic [10:0] V_LAST_W    = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_START_W  = 11'(V_FP);
  localparam logic [10:0] VS_END_W    = 11'(V_FP + V_SYNC);

  // The preamble and guard band must fit inside the back porch so that they
  // never overlap the sync pulse.
  if (HDMI_MODE && (H_BP < 10)) begin : g_bp_check
    $error("hdmi_period_sched: H_BP must be >= 10 when HDMI_MODE=1");
  end
  if ((H_TOTAL > 2047) || (V_TOTAL > 2047)) begin : g_width_check
    $error("hdmi_period_sched: H_TOTAL/V_TOTAL exceed the 11-bit counters");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_PREAMBLE,
    ST_GUARD,
    ST_ACTIVE
  } state_e;

  // state_q is the period that applies to the current (hcnt_q, vcnt_q).
  state_e      state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;

  logic        blank_q, blank_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        guard_q, guard_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Scratch values shared by the next-state logic.
  state_e      cur_state;
  logic        h_wrap;
  logic [10:0] nxt_h;
  logic [10:0] nxt_v;
  logic        nxt_active_line;

  // Next counter position, next period and the registered outputs for the
  // current position.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    blank_d       = 1'b1;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    ctl_d         = 4'b0000;
    guard_d       = 1'b0;
    xpos_d        = '0;
    ypos_d        = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    // Leaving IDLE the counters already sit at the frame origin, which is a
    // control-period position.
    cur_state       = (state_q == ST_IDLE) ? ST_CTRL : state_q;
    h_wrap          = (hcnt_q == H_LAST_W);
    nxt_h           = h_wrap ? '0 : hcnt_q + 11'd1;
    nxt_v           = h_wrap ? ((vcnt_q == V_LAST_W) ? '0 : vcnt_q + 11'd1) : vcnt_q;
    nxt_active_line = (nxt_v >= V_BLANK_W);

    if (!enable) begin
      // Abort the frame: counters back to the origin, outputs at reset values.
      state_d = ST_IDLE;
      hcnt_d  = '0;
      vcnt_d  = '0;
    end else begin
      hcnt_d = nxt_h;
      vcnt_d = nxt_v;

      unique case (cur_state)
        ST_CTRL: begin
          if (HDMI_MODE && nxt_active_line && (nxt_h == PRE_START_W)) begin
            state_d = ST_PREAMBLE;
          end else if (!HDMI_MODE && nxt_active_line && (nxt_h == H_BLANK_W)) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_CTRL;
          end
        end
        ST_PREAMBLE: state_d = (nxt_h == GRD_START_W) ? ST_GUARD : ST_PREAMBLE;
        ST_GUARD:    state_d = (nxt_h == H_BLANK_W) ? ST_ACTIVE : ST_GUARD;
        ST_ACTIVE:   state_d = h_wrap ? ST_CTRL : ST_ACTIVE;
        default:     state_d = ST_CTRL;
      endcase

      blank_d       = (cur_state != ST_ACTIVE);
      ctl_d         = (cur_state == ST_PREAMBLE) ? 4'b0001 : 4'b0000;
      guard_d       = (cur_state == ST_GUARD);
      xpos_d        = (cur_state == ST_ACTIVE) ? hcnt_q - H_BLANK_W : '0;
      ypos_d        = (vcnt_q >= V_BLANK_W) ? vcnt_q - V_BLANK_W : '0;
      hsync_d       = ((hcnt_q >= HS_START_W) && (hcnt_q < HS_END_W)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((vcnt_q >= VS_START_W) && (vcnt_q < VS_END_W)) ? VSYNC_POL : ~VSYNC_POL;
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      ctl_q         <= 4'b0000;
      guard_q       <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      ctl_q         <= ctl_d;
      guard_q       <= guard_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign ctl         = ctl_q;
  assign guard       = guard_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_period_sched.sv
// Testbench for hdmi_period_sched. Horizontal timing uses the defaults; the
// vertical back porch and active height are reduced (V_BLANK=15, V_TOTAL=26)
// so a full frame is 20800 cycles. An HDMI instance and a DVI instance run
// side by side on the same inputs.
module tb_hdmi_period_sched;

  localparam int HT    = 800;
  localparam int VB    = 15;
  localparam int VT    = 26;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;

  logic        blank, hsync, vsync, guard, line_start, frame_start;
  logic [3:0]  ctl;
  logic [10:0] xpos, ypos;

  logic        d_blank, d_hsync, d_vsync, d_guard, d_line_start, d_frame_start;
  logic [3:0]  d_ctl;
  logic [10:0] d_xpos, d_ypos;

  always #5 clk = ~clk;

  hdmi_period_sched #(.V_BP(3), .V_ACTIVE(11), .HDMI_MODE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .blank(blank), .hsync(hsync), .vsync(vsync), .ctl(ctl), .guard(guard),
    .xpos(xpos), .ypos(ypos), .line_start(line_start), .frame_start(frame_start)
  );

  hdmi_period_sched #(.V_BP(3), .V_ACTIVE(11), .HDMI_MODE(1'b0)) dut_dvi (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .blank(d_blank), .hsync(d_hsync), .vsync(d_vsync), .ctl(d_ctl), .guard(d_guard),
    .xpos(d_xpos), .ypos(d_ypos), .line_start(d_line_start), .frame_start(d_frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic hs, input logic vs,
                           input logic [3:0] c, input logic g, input int x, input int y,
                           input logic ls, input logic fs);
    check({tag, ".blank"}, 32'(blank), 32'(b));
    check({tag, ".hsync"}, 32'(hsync), 32'(hs));
    check({tag, ".vsync"}, 32'(vsync), 32'(vs));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".guard"}, 32'(guard), 32'(g));
    check({tag, ".xpos"}, 32'(xpos), x);
    check({tag, ".ypos"}, 32'(ypos), y);
    check({tag, ".line_start"}, 32'(line_start), 32'(ls));
    check({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
  endtask

  // Expected outputs at a frame/line/pixel position.
  typedef struct {
    int f; int h; int v;
    logic b; logic hs; logic vs; logic [3:0] c; logic g;
    int x; int y; logic ls; logic fs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int f, input int h, input int v, input logic b, input logic hs,
                     input logic vs, input logic [3:0] c, input logic g, input int x,
                     input int y, input logic ls, input logic fs);
    vec_t t;
    t.f = f; t.h = h; t.v = v; t.b = b; t.hs = hs; t.vs = vs; t.c = c; t.g = g;
    t.x = x; t.y = y; t.ls = ls; t.fs = fs;
    vecs.push_back(t);
  endtask

  // cyc counts sampled output cycles since the last start; the outputs at
  // cycle cyc describe position cyc-1.
  int cyc = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_pos(input int f, input int v, input int h);
    while (cyc - 1 < f * FRAME + v * HT + h) step();
  endtask

  // Frame-wide statistics over the first frame, plus frame_start spacing.
  logic mon_armed = 1'b0;
  int mpos = 0, gcyc = 0, fs_last = 0, fs_seen = 0, fs_period = 0;
  int bl_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
  int vs_cnt = 0, vs_bad = 0, pg_bad = 0, pre_cnt = 0, grd_cnt = 0, dvi_bad = 0;

  always @(negedge clk) begin
    if (mon_armed) begin
      gcyc <= gcyc + 1;
      if (frame_start) begin
        if (fs_seen == 1 && fs_period == 0) fs_period <= gcyc - fs_last;
        fs_last <= gcyc;
        fs_seen <= fs_seen + 1;
      end
      if (mpos < FRAME) begin
        mpos <= mpos + 1;
        if (!blank) bl_cnt <= bl_cnt + 1;
        if ((mpos / HT) == 0 && !hsync) begin
          hs_cnt <= hs_cnt + 1;
          if (hs_first < 0) hs_first <= mpos % HT;
          hs_last <= mpos % HT;
        end
        if (!vsync) begin
          vs_cnt <= vs_cnt + 1;
          if ((mpos / HT) < 10 || (mpos / HT) > 11) vs_bad <= vs_bad + 1;
        end
        if ((mpos / HT) == VB - 1 && (ctl != 4'b0000 || guard)) pg_bad <= pg_bad + 1;
        if (ctl == 4'b0001) pre_cnt <= pre_cnt + 1;
        if (guard) grd_cnt <= grd_cnt + 1;
        if (d_blank !== blank || d_hsync !== hsync || d_vsync !== vsync ||
            d_xpos !== xpos || d_ypos !== ypos || d_ctl !== 4'b0000 || d_guard !== 1'b0)
          dvi_bad <= dvi_bad + 1;
      end
    end
  end

  initial begin
    //  f  h    v   b  hs vs ctl      g  x    y   ls fs
    add(0, 0,   0,  1, 1, 1, 4'b0000, 0, 0,   0,  1, 1);
    add(0, 1,   0,  1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 15,  0,  1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 16,  0,  1, 0, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 111, 0,  1, 0, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 112, 0,  1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 799, 9,  1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 0,   10, 1, 1, 0, 4'b0000, 0, 0,   0,  1, 0);
    add(0, 799, 11, 1, 1, 0, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 0,   12, 1, 1, 1, 4'b0000, 0, 0,   0,  1, 0);
    add(0, 150, 14, 1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 159, 14, 1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 160, 14, 1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 20,  15, 1, 0, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 149, 15, 1, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 150, 15, 1, 1, 1, 4'b0001, 0, 0,   0,  0, 0);
    add(0, 157, 15, 1, 1, 1, 4'b0001, 0, 0,   0,  0, 0);
    add(0, 158, 15, 1, 1, 1, 4'b0000, 1, 0,   0,  0, 0);
    add(0, 159, 15, 1, 1, 1, 4'b0000, 1, 0,   0,  0, 0);
    add(0, 160, 15, 0, 1, 1, 4'b0000, 0, 0,   0,  0, 0);
    add(0, 161, 15, 0, 1, 1, 4'b0000, 0, 1,   0,  0, 0);
    add(0, 799, 15, 0, 1, 1, 4'b0000, 0, 639, 0,  0, 0);
    add(0, 0,   16, 1, 1, 1, 4'b0000, 0, 0,   1,  1, 0);
    add(0, 460, 25, 0, 1, 1, 4'b0000, 0, 300, 10, 0, 0);
    add(0, 799, 25, 0, 1, 1, 4'b0000, 0, 639, 10, 0, 0);
    add(1, 0,   0,  1, 1, 1, 4'b0000, 0, 0,   0,  1, 1);

    reset_n = 1'b0;
    enable  = 1'b1;
    #12;
    check_all("reset", 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
    check("reset.dvi_blank", 32'(d_blank), 32'd1);

    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    mon_armed = 1'b1;
    @(negedge clk);
    cyc = 1;

    foreach (vecs[i]) begin
      goto_pos(vecs[i].f, vecs[i].v, vecs[i].h);
      check_all($sformatf("vec%0d_f%0d_v%0d_h%0d", i, vecs[i].f, vecs[i].v, vecs[i].h),
                vecs[i].b, vecs[i].hs, vecs[i].vs, vecs[i].c, vecs[i].g,
                vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs);
    end
    step();

    check("frame_period", fs_period, FRAME);
    check("active_pixels", bl_cnt, 640 * 11);
    check("hsync_low_cycles", hs_cnt, 96);
    check("hsync_first_h", hs_first, 16);
    check("hsync_last_h", hs_last, 111);
    check("vsync_low_cycles", vs_cnt, 2 * HT);
    check("vsync_outside_lines", vs_bad, 0);
    check("blank_line_pre_guard", pg_bad, 0);
    check("preamble_cycles", pre_cnt, 8 * 11);
    check("guard_cycles", grd_cnt, 2 * 11);
    check("dvi_differences", dvi_bad, 0);

    // Drop enable while the outputs show xpos=300 on ypos=10.
    goto_pos(1, 25, 460);
    check_all("pre_drop", 0, 1, 1, 4'b0000, 0, 300, 10, 0, 0);
    enable = 1'b0;
    step();
    check_all("drop", 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
    repeat (3) step();
    check_all("idle", 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
    enable = 1'b1;
    step();
    check_all("restart", 1, 1, 1, 4'b0000, 0, 0, 0, 1, 1);
    cyc = 1;
    goto_pos(0, 0, 16);
    check("restart_hsync_h16", 32'(hsync), 32'd0);
    goto_pos(0, 15, 200);
    check_all("restart_active", 0, 1, 1, 4'b0000, 0, 40, 0, 0, 0);

    // Asynchronous reset in the middle of active video, between clock edges.
    #2 reset_n = 1'b0;
    #1;
    check_all("async_reset", 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_all("post_reset", 1, 1, 1, 4'b0000, 0, 0, 0, 1, 1);
    cyc = 1;
    goto_pos(0, 0, 16);
    check("post_reset_hsync_h16", 32'(hsync), 32'd0);
    goto_pos(0, 1, 0);
    check_all("post_reset_line1", 1, 1, 1, 4'b0000, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
